// File: rtl/wishbone_arbiter.sv
// -----------------------------------------------------------------------------
// wishbone_arbiter
//
// Shares a single Wishbone slave port among NUM_MASTERS requesters using
// round-robin arbitration. The grant is held for a master's entire bus cycle,
// from the rise of its cyc until it drops. At least one idle cycle always
// separates two owners.
//
// A bus watchdog answers err to the owner when a strobed transfer goes
// unanswered for TIMEOUT cycles. The CPU then traps instead of hanging.
//
// Ports
//   clk               system clock
//   rst_n             asynchronous active-low reset
//   masters_cyc/stb/we/adr/dat_mosi   requester-side request signals, per master
//   masters_ack/err/dat_miso          requester-side responses, per master
//                                     (index 0 wins ties out of reset)
//   slave_cyc/stb/we/adr/dat_mosi     shared downstream request
//   slave_ack/err/dat_miso            shared downstream response
//   grant             one-hot current owner, all-zero when idle
//   timeout_pulse     one-cycle pulse, the cycle after the watchdog fires
// -----------------------------------------------------------------------------
module wishbone_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int TIMEOUT     = 16,
    parameter int DATA_W      = 32,
    parameter int ADR_W       = 32
) (
    input  logic                                clk,
    input  logic                                rst_n,

    input  logic [NUM_MASTERS-1:0]              masters_cyc,
    input  logic [NUM_MASTERS-1:0]              masters_stb,
    input  logic [NUM_MASTERS-1:0]              masters_we,
    input  logic [NUM_MASTERS-1:0][ADR_W-1:0]   masters_adr,
    input  logic [NUM_MASTERS-1:0][DATA_W-1:0]  masters_dat_mosi,
    output logic [NUM_MASTERS-1:0]              masters_ack,
    output logic [NUM_MASTERS-1:0]              masters_err,
    output logic [NUM_MASTERS-1:0][DATA_W-1:0]  masters_dat_miso,

    output logic                                slave_cyc,
    output logic                                slave_stb,
    output logic                                slave_we,
    output logic [ADR_W-1:0]                    slave_adr,
    output logic [DATA_W-1:0]                   slave_dat_mosi,
    input  logic                                slave_ack,
    input  logic                                slave_err,
    input  logic [DATA_W-1:0]                   slave_dat_miso,

    output logic [NUM_MASTERS-1:0]              grant,
    output logic                                timeout_pulse
);

    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int WD_W  = $clog2(TIMEOUT) + 1;

    localparam logic [IDX_W-1:0]       LAST_IDX = IDX_W'(NUM_MASTERS - 1);
    localparam logic [WD_W-1:0]        WD_LIMIT = WD_W'(TIMEOUT - 1);
    localparam logic [NUM_MASTERS-1:0] ONE_HOT0 = NUM_MASTERS'(1);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       owner_q, owner_d;
    logic [IDX_W-1:0]       rr_q, rr_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [WD_W-1:0]        wdog_q, wdog_d;
    logic                   timeout_pulse_q;

    logic                   owner_cyc;
    logic                   owner_stb;
    logic                   wdog_fire;
    logic [IDX_W-1:0]       winner;

    // First requester found when searching upward from 'start', wrapping at
    // NUM_MASTERS. The caller only uses the result when some request is set.
    function automatic logic [IDX_W-1:0] rr_pick(
        input logic [NUM_MASTERS-1:0] req,
        input logic [IDX_W-1:0]       start
    );
        logic [IDX_W-1:0] sel;
        logic             found;
        int               idx;
        sel   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            idx = int'(start) + k;
            if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
            if (!found && req[idx]) begin
                found = 1'b1;
                sel   = IDX_W'(idx);
            end
        end
        return sel;
    endfunction

    assign owner_cyc = masters_cyc[owner_q];
    assign owner_stb = masters_stb[owner_q];
    assign winner    = rr_pick(masters_cyc, rr_q);

    // The watchdog fires only if the slave is still silent in the limit cycle.
    // A slave response arriving in that same cycle takes priority.
    assign wdog_fire = (state_q == BUSY) && owner_cyc && owner_stb &&
                       !slave_ack && !slave_err && (wdog_q == WD_LIMIT);

    // ---- state register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            owner_q         <= '0;
            rr_q            <= '0;
            grant_q         <= '0;
            wdog_q          <= '0;
            timeout_pulse_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            owner_q         <= owner_d;
            rr_q            <= rr_d;
            grant_q         <= grant_d;
            wdog_q          <= wdog_d;
            timeout_pulse_q <= wdog_fire;
        end
    end

    // ---- next-state logic ----
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        grant_d = grant_q;
        wdog_d  = '0;

        case (state_q)
            IDLE: begin
                if (|masters_cyc) begin
                    state_d = BUSY;
                    owner_d = winner;
                    grant_d = ONE_HOT0 << winner;
                end
            end
            BUSY: begin
                if (!owner_cyc) begin
                    state_d = IDLE;
                    grant_d = '0;
                    rr_d    = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
                end
                // The counter only advances while a strobe waits on a silent
                // slave. Any other case clears it, including release.
                if (owner_cyc && owner_stb && !slave_ack && !slave_err && !wdog_fire)
                    wdog_d = wdog_q + 1'b1;
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // ---- output logic ----
    always_comb begin
        slave_cyc      = 1'b0;
        slave_stb      = 1'b0;
        slave_we       = 1'b0;
        slave_adr      = '0;
        slave_dat_mosi = '0;
        masters_ack      = '0;
        masters_err      = '0;
        masters_dat_miso = '0;

        if (state_q == BUSY) begin
            slave_cyc      = owner_cyc;
            // The strobe is withdrawn in the cycle the watchdog answers. This
            // keeps a late slave response from reaching the owner twice.
            slave_stb      = owner_stb && !wdog_fire;
            slave_we       = masters_we[owner_q];
            slave_adr      = masters_adr[owner_q];
            slave_dat_mosi = masters_dat_mosi[owner_q];
            for (int i = 0; i < NUM_MASTERS; i++) begin
                if (grant_q[i]) begin
                    masters_ack[i]      = slave_ack;
                    masters_err[i]      = slave_err || wdog_fire;
                    masters_dat_miso[i] = slave_dat_miso;
                end
            end
        end
    end

    assign grant         = grant_q;
    assign timeout_pulse = timeout_pulse_q;

endmodule

// File: tb/tb_wishbone_arbiter.sv
module tb_wishbone_arbiter;

    localparam int NM = 2;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TO = 16;

    logic                     clk;
    logic                     rst_n;
    logic [NM-1:0]            masters_cyc;
    logic [NM-1:0]            masters_stb;
    logic [NM-1:0]            masters_we;
    logic [NM-1:0][AW-1:0]    masters_adr;
    logic [NM-1:0][DW-1:0]    masters_dat_mosi;
    logic [NM-1:0]            masters_ack;
    logic [NM-1:0]            masters_err;
    logic [NM-1:0][DW-1:0]    masters_dat_miso;
    logic                     slave_cyc;
    logic                     slave_stb;
    logic                     slave_we;
    logic [AW-1:0]            slave_adr;
    logic [DW-1:0]            slave_dat_mosi;
    logic                     slave_ack;
    logic                     slave_err;
    logic [DW-1:0]            slave_dat_miso;
    logic [NM-1:0]            grant;
    logic                     timeout_pulse;

    int n_cmp = 0;
    int n_bad = 0;

    wishbone_arbiter #(
        .NUM_MASTERS(NM),
        .TIMEOUT    (TO),
        .DATA_W     (DW),
        .ADR_W      (AW)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .masters_cyc     (masters_cyc),
        .masters_stb     (masters_stb),
        .masters_we      (masters_we),
        .masters_adr     (masters_adr),
        .masters_dat_mosi(masters_dat_mosi),
        .masters_ack     (masters_ack),
        .masters_err     (masters_err),
        .masters_dat_miso(masters_dat_miso),
        .slave_cyc       (slave_cyc),
        .slave_stb       (slave_stb),
        .slave_we        (slave_we),
        .slave_adr       (slave_adr),
        .slave_dat_mosi  (slave_dat_mosi),
        .slave_ack       (slave_ack),
        .slave_err       (slave_err),
        .slave_dat_miso  (slave_dat_miso),
        .grant           (grant),
        .timeout_pulse   (timeout_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n            = 1'b0;
        masters_cyc      = '0;
        masters_stb      = '0;
        masters_we       = '0;
        masters_adr      = '0;
        masters_dat_mosi = '0;
        slave_ack        = 1'b0;
        slave_err        = 1'b0;
        slave_dat_miso   = '0;

        // Reset state
        tick(); tick();
        check("rst_grant", 64'(grant), 64'h0);
        check("rst_scyc", 64'(slave_cyc), 64'h0);
        check("rst_pulse", 64'(timeout_pulse), 64'h0);
        check("rst_ack", 64'(masters_ack), 64'h0);
        rst_n = 1'b1;
        tick();

        // Contention right after reset: m0 wins, then m1 after one idle cycle
        masters_cyc = 2'b11;
        #1;
        check("cont_idle_scyc", 64'(slave_cyc), 64'h0);
        tick();
        check("cont_grant_m0", 64'(grant), 64'h1);
        check("cont_m1_noack", 64'(masters_ack[1]), 64'h0);
        masters_cyc[0] = 1'b0;
        tick();
        check("cont_idle_gap", 64'(grant), 64'h0);
        check("cont_gap_scyc", 64'(slave_cyc), 64'h0);
        tick();
        check("cont_grant_m1", 64'(grant), 64'h2);
        masters_cyc[1] = 1'b0;
        tick();
        check("cont_release", 64'(grant), 64'h0);

        // Single master write, slave acks immediately
        masters_cyc[0]      = 1'b1;
        masters_stb[0]      = 1'b1;
        masters_we[0]       = 1'b1;
        masters_adr[0]      = 32'h0000_0100;
        masters_dat_mosi[0] = 32'h1234_5678;
        #1;
        check("wr_lat_scyc", 64'(slave_cyc), 64'h0);
        tick();
        check("wr_scyc", 64'(slave_cyc), 64'h1);
        check("wr_grant", 64'(grant), 64'h1);
        check("wr_adr", 64'(slave_adr), 64'h100);
        check("wr_dat", 64'(slave_dat_mosi), 64'h1234_5678);
        check("wr_we", 64'(slave_we), 64'h1);
        slave_ack = 1'b1;
        #1;
        check("wr_ack", 64'(masters_ack), 64'h1);
        tick();
        slave_ack      = 1'b0;
        masters_cyc[0] = 1'b0;
        masters_stb[0] = 1'b0;
        masters_we[0]  = 1'b0;
        #1;
        check("wr_drop_scyc", 64'(slave_cyc), 64'h0);
        tick();
        check("wr_release", 64'(grant), 64'h0);

        // rr now points at m1: simultaneous request goes to m1, which then
        // performs three locked reads while m0 waits
        masters_cyc = 2'b11;
        tick();
        check("lock_grant_m1", 64'(grant), 64'h2);
        for (int i = 0; i < 3; i++) begin
            masters_stb[1] = 1'b1;
            slave_ack      = 1'b1;
            slave_dat_miso = 32'hA000_0000 + 32'(i);
            #1;
            check("lock_ack", 64'(masters_ack), 64'h2);
            check("lock_err", 64'(masters_err), 64'h0);
            check("lock_data", 64'(masters_dat_miso[1]), 64'hA000_0000 + 64'(i));
            check("lock_m0_data", 64'(masters_dat_miso[0]), 64'h0);
            tick();
            masters_stb[1] = 1'b0;
            slave_ack      = 1'b0;
            tick();
            check("lock_hold", 64'(grant), 64'h2);
        end
        masters_cyc[1] = 1'b0;
        tick();
        check("lock_release", 64'(grant), 64'h0);
        tick();
        check("lock_grant_m0", 64'(grant), 64'h1);

        // Watchdog: silent slave, err in the 16th strobed cycle
        masters_stb[0] = 1'b1;
        #1;
        for (int c = 1; c < TO; c++) begin
            check("to_wait_err", 64'(masters_err), 64'h0);
            tick();
        end
        check("to_err", 64'(masters_err), 64'h1);
        check("to_stb_forced", 64'(slave_stb), 64'h0);
        check("to_pulse_early", 64'(timeout_pulse), 64'h0);
        tick();
        check("to_pulse", 64'(timeout_pulse), 64'h1);
        check("to_err_clear", 64'(masters_err), 64'h0);
        check("to_owner_kept", 64'(grant), 64'h1);
        tick();
        check("to_pulse_once", 64'(timeout_pulse), 64'h0);

        // Slave acks in exactly the 16th cycle: response wins
        masters_stb[0] = 1'b0;
        tick();
        masters_stb[0] = 1'b1;
        #1;
        for (int c = 1; c < TO; c++) tick();
        slave_ack = 1'b1;
        #1;
        check("race_ack", 64'(masters_ack), 64'h1);
        check("race_err", 64'(masters_err), 64'h0);
        check("race_stb", 64'(slave_stb), 64'h1);
        tick();
        slave_ack      = 1'b0;
        masters_stb[0] = 1'b0;
        check("race_pulse", 64'(timeout_pulse), 64'h0);
        tick();

        // Stalling slave: three wait states, then data
        masters_stb[0] = 1'b1;
        #1;
        for (int c = 0; c < 3; c++) begin
            check("stall_ack", 64'(masters_ack), 64'h0);
            check("stall_err", 64'(masters_err), 64'h0);
            tick();
        end
        slave_ack      = 1'b1;
        slave_dat_miso = 32'hCAFE_F00D;
        #1;
        check("stall_done", 64'(masters_ack), 64'h1);
        check("stall_data", 64'(masters_dat_miso[0]), 64'hCAFE_F00D);
        tick();
        slave_ack      = 1'b0;
        masters_stb[0] = 1'b0;
        check("stall_pulse", 64'(timeout_pulse), 64'h0);

        // Asynchronous reset between edges while m0 still owns the bus
        #2;
        check("ar_pre_grant", 64'(grant), 64'h1);
        rst_n = 1'b0;
        #1;
        check("ar_scyc", 64'(slave_cyc), 64'h0);
        check("ar_grant", 64'(grant), 64'h0);
        tick();
        masters_cyc = 2'b11;
        tick();
        check("ar_hold_grant", 64'(grant), 64'h0);
        rst_n = 1'b1;
        tick();
        check("ar_grant_m0", 64'(grant), 64'h1);

        masters_cyc = '0;
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
